// File: rtl/xor_stream_descrambler_pkg.sv
// Shared constants and state encoding for the XOR keystream scrambler/descrambler pair.
// Both ends of the link import this package so that their keystreams match.
package xor_stream_descrambler_pkg;

    localparam logic [31:0] POLY_CRC32   = 32'h04C1_1DB7;
    localparam logic [31:0] DEFAULT_SEED = 32'hFFFF_FFFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // An all-zero LFSR would lock up, so a zero seed is replaced by the default seed.
    function automatic logic [31:0] seed_fix(input logic [31:0] seed,
                                             input logic [31:0] dflt);
        return (seed == '0) ? dflt : seed;
    endfunction

endpackage

// File: rtl/xor_stream_descrambler_lfsr32_step.sv
// One Galois LFSR step: shift left, then XOR in POLY if the bit shifted out was 1.
// Purely combinational; the transmit-side scrambler uses the same block.
module lfsr32_step #(
    parameter logic [31:0] POLY = 32'h04C1_1DB7
) (
    input  logic [31:0] cur,
    output logic [31:0] nxt
);

    always_comb begin
        nxt = {cur[30:0], 1'b0} ^ (cur[31] ? POLY : '0);
    end

endmodule

// File: rtl/xor_stream_descrambler.sv
// Receive-side XOR keystream descrambler: valid/ready input, one registered output
// stage with full-throughput backpressure, keystream advanced once per accepted word.
module xor_stream_descrambler
    import xor_stream_descrambler_pkg::*;
#(
    parameter logic [31:0] POLY         = POLY_CRC32,
    parameter logic [31:0] DEFAULT_SEED = 32'hFFFF_FFFF,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [31:0]      seed_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] word_count,
    output logic             busy
);

    state_t      state;
    state_t      state_nx;
    logic [31:0] lfsr;
    logic [31:0] lfsr_nx;
    logic        accept;

    lfsr32_step #(.POLY(POLY)) u_step (
        .cur (lfsr),
        .nxt (lfsr_nx)
    );

    always_comb begin
        state_nx = state;
        if (seed_load) begin
            state_nx = ST_RUN;
        end
    end

    // Accepts are blocked during seed_load so no word is XORed with the outgoing key.
    always_comb begin
        in_ready = (state == ST_RUN) & ~seed_load & (~out_valid | out_ready);
        accept   = in_valid & in_ready;
        busy     = (state == ST_RUN) | out_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            lfsr       <= DEFAULT_SEED;
            out_valid  <= 1'b0;
            out_data   <= '0;
            word_count <= '0;
        end else begin
            state <= state_nx;

            if (seed_load) begin
                lfsr       <= seed_fix(seed_in, DEFAULT_SEED);
                word_count <= '0;
            end else if (accept) begin
                lfsr       <= lfsr_nx;
                word_count <= word_count + CNT_W'(1);
            end

            // A pending word survives seed_load and simply drains.
            if (accept) begin
                out_data  <= in_data ^ lfsr;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_xor_stream_descrambler.sv
// Directed bench for xor_stream_descrambler with a short random loopback section.
module tb_xor_stream_descrambler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        seed_load;
    logic [31:0] seed_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] word_count;
    logic        busy;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    xor_stream_descrambler #(
        .POLY         (32'h04C1_1DB7),
        .DEFAULT_SEED (32'hFFFF_FFFF),
        .CNT_W        (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .word_count (word_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] kstep(input logic [31:0] x);
        logic [31:0] r;
        r = x << 1;
        if (x[31]) r = r ^ 32'h04C1_1DB7;
        return r;
    endfunction

    initial begin
        logic [31:0] key;
        logic [31:0] pt;
        logic [31:0] exp_w;
        logic        acc;
        logic        drn;
        logic [31:0] q[$];
        int unsigned sent;
        int unsigned got;
        int unsigned cyc;

        rst_n = 1'b0; seed_load = 1'b0; seed_in = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();

        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Input offered before any seed must be refused.
        rst_n = 1'b1; in_valid = 1'b1; in_data = 32'h1234_5678;
        tick(); tick(); tick();
        check("idle_in_ready", 32'(in_ready), 32'd0);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_word_count", 32'(word_count), 32'd0);

        seed_load = 1'b1; seed_in = 32'h1;
        #1;
        check("seed_cycle_in_ready", 32'(in_ready), 32'd0);
        tick();
        seed_load = 1'b0; in_data = 32'hA5A5_A5A5; out_ready = 1'b1;
        #1;
        check("run_in_ready", 32'(in_ready), 32'd1);
        check("run_busy", 32'(busy), 32'd1);
        tick();
        check("w1_data", out_data, 32'hA5A5_A5A4);
        check("w1_valid", 32'(out_valid), 32'd1);
        check("w1_count", 32'(word_count), 32'd1);

        // Keystream from seed 1 walks a single 1 up to bit 31, then feeds back POLY.
        in_data = '0;
        for (int k = 2; k <= 33; k++) begin
            tick();
            if (k == 2)  check("w2_data", out_data, 32'h0000_0002);
            if (k == 32) check("w32_data", out_data, 32'h8000_0000);
            if (k == 33) check("w33_data", out_data, 32'h04C1_1DB7);
        end
        check("w33_count", 32'(word_count), 32'd33);

        in_valid = 1'b0; seed_load = 1'b1; seed_in = 32'h0;
        tick();
        seed_load = 1'b0;
        check("reseed_count", 32'(word_count), 32'd0);
        check("reseed_drained", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_data = '0;
        tick();
        check("zero_seed_data", out_data, 32'hFFFF_FFFF);
        check("zero_seed_count", 32'(word_count), 32'd1);

        // Backpressure: output held, nothing accepted.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
            check("stall_data", out_data, 32'hFFFF_FFFF);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_count", 32'(word_count), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        check("release_w2", out_data, 32'hFB3E_E249);
        check("release_c2", 32'(word_count), 32'd2);
        tick();
        check("release_w3", out_data, 32'hF2BC_D925);
        check("release_c3", 32'(word_count), 32'd3);
        in_valid = 1'b0;
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_busy", 32'(busy), 32'd1);

        // Loopback against a bench-side scrambler with random stalls.
        key = 32'h1357_9BDF;
        seed_in = key; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        sent = 0; got = 0; cyc = 0;
        while ((sent < 300 || got < sent) && cyc < 5000) begin
            pt        = $urandom;
            in_valid  = (sent < 300) && ($urandom_range(0, 3) != 0);
            in_data   = pt ^ key;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = in_valid & in_ready;
            drn = out_valid & out_ready;
            if (drn) begin
                exp_w = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
                check("loop_data", out_data, exp_w);
                got++;
            end
            if (acc) begin
                q.push_back(pt);
                key = kstep(key);
                sent++;
            end
            tick();
            cyc++;
        end
        check("loop_words_sent", sent, 32'd300);
        check("loop_words_recv", got, 32'd300);
        check("loop_count", 32'(word_count), 32'd300);

        // Reset with a word pending discards it.
        in_valid = 1'b1; in_data = 32'hCAFE_F00D; out_ready = 1'b0;
        tick();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_count", 32'(word_count), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
